siggen_trig_rx: RTL

Receive-side counterpart of the signal-generator trigger link. It sits at the signal-generator/acquisition end and samples the asynchronous trigger square wave. After synchronising and glitch-filtering the input, it emits one start pulse per rising edge, measures the edge-to-edge period, and counts triggers against an expected burst length. It flags out-of-range periods and a lost trigger (timeout), so firmware can confirm that a full burst arrived at the intended rate (nominally 40 Hz, 2 500 000 cycles at 100 MHz).

---
 rtl/siggen_trig_pkg.sv | 18 +
 rtl/siggen_trig_rx_if.sv | 23 ++
 rtl/trig_sync_filter.sv | 48 ++++
 rtl/siggen_trig_rx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/siggen_trig_pkg.sv
// Shared state encoding and default timing for the signal-generator trigger receiver.
package siggen_trig_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    RUN       = 2'd2,
    HALT      = 2'd3
  } state_e;

  localparam int unsigned CLK_HZ      = 100_000_000;
  localparam int unsigned TRIG_PERIOD = CLK_HZ / 40;
  // Legal window is the nominal period +/- 4 %; loss declared after two missed periods.
  localparam int unsigned DEF_PER_MIN = TRIG_PERIOD - TRIG_PERIOD / 25;
  localparam int unsigned DEF_PER_MAX = TRIG_PERIOD + TRIG_PERIOD / 25;
  localparam int unsigned DEF_TIMEOUT = 2 * TRIG_PERIOD;

endpackage

// File: rtl/siggen_trig_rx_if.sv
// Trigger receiver control/status bundle; master drives trigger and arm, slave reports status.
interface siggen_trig_rx_if;
  logic        trig_in;
  logic        arm;
  logic [15:0] exp_count;
  logic        start_pulse;
  logic [15:0] trig_count;
  logic [31:0] last_period;
  logic        period_err;
  logic        timeout;
  logic        done;
  logic [1:0]  state;

  modport master (
    output trig_in, arm, exp_count,
    input  start_pulse, trig_count, last_period, period_err, timeout, done, state
  );

  modport slave (
    input  trig_in, arm, exp_count,
    output start_pulse, trig_count, last_period, period_err, timeout, done, state
  );
endinterface

// File: rtl/trig_sync_filter.sv
// Synchroniser plus run-length glitch filter; rise is a registered one-cycle pulse on 0->1.
module trig_sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic clki,
  input  logic reset,
  input  logic din,
  output logic rise
);

  localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q;

  // Count consecutive samples that disagree with the filtered level; flip on the FILT_LEN-th.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[SYNC_STAGES-1] != level_q) begin
      if (cnt_q == CntW'(FILT_LEN - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clki) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/siggen_trig_rx.sv
// Trigger receiver: start pulse per filtered rising edge, period measurement, burst count.
module siggen_trig_rx
  import siggen_trig_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned PER_MIN     = DEF_PER_MIN,
  parameter int unsigned PER_MAX     = DEF_PER_MAX,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input logic              clki,
  input logic              reset,
  siggen_trig_rx_if.slave  bus
);

  state_e      state_q, state_d;
  logic        rise, arm_q, arm_edge;
  logic [15:0] exp_q, exp_d, trig_count_q, trig_count_d, new_count;
  logic [31:0] last_period_q, last_period_d, per_cnt_q, per_cnt_d, wait_cnt_q, wait_cnt_d;
  logic        period_err_q, period_err_d, timeout_q, timeout_d, done_q, done_d;
  logic        start_pulse_q, start_pulse_d;
  logic        wait_hit, per_hit, done_hit, per_bad;

  trig_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_filt (
    .clki  (clki),
    .reset (reset),
    .din   (bus.trig_in),
    .rise  (rise)
  );

  assign arm_edge  = bus.arm & ~arm_q;
  assign new_count = (trig_count_q == 16'hFFFF) ? trig_count_q : trig_count_q + 16'd1;
  assign done_hit  = (exp_q != 16'd0) && (new_count == exp_q);
  assign per_bad   = (per_cnt_q < PER_MIN) || (per_cnt_q > PER_MAX);
  assign wait_hit  = (wait_cnt_q == TIMEOUT - 1);
  assign per_hit   = (per_cnt_q == TIMEOUT);

  always_ff @(posedge clki) begin
    if (reset) begin
      state_q       <= IDLE;
      arm_q         <= 1'b0;
      exp_q         <= '0;
      trig_count_q  <= '0;
      last_period_q <= '0;
      per_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      period_err_q  <= 1'b0;
      timeout_q     <= 1'b0;
      done_q        <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      arm_q         <= bus.arm;
      exp_q         <= exp_d;
      trig_count_q  <= trig_count_d;
      last_period_q <= last_period_d;
      per_cnt_q     <= per_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      period_err_q  <= period_err_d;
      timeout_q     <= timeout_d;
      done_q        <= done_d;
      start_pulse_q <= start_pulse_d;
    end
  end

  // A rise takes priority over a coincident timeout compare.
  always_comb begin
    state_d = state_q;
    if (!bus.arm) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      if (arm_edge) state_d = WAIT_EDGE;
        WAIT_EDGE: begin
          if (rise) state_d = done_hit ? HALT : RUN;
          else if (wait_hit) state_d = HALT;
        end
        RUN: begin
          if (rise) begin
            if (done_hit) state_d = HALT;
          end else if (per_hit) begin
            state_d = HALT;
          end
        end
        HALT:      state_d = HALT;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    exp_d         = exp_q;
    trig_count_d  = trig_count_q;
    last_period_d = last_period_q;
    per_cnt_d     = per_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    period_err_d  = period_err_q;
    timeout_d     = timeout_q;
    done_d        = done_q;
    start_pulse_d = 1'b0;
    if (bus.arm) begin
      unique case (state_q)
        IDLE: begin
          if (arm_edge) begin
            exp_d         = bus.exp_count;
            trig_count_d  = '0;
            last_period_d = '0;
            per_cnt_d     = '0;
            wait_cnt_d    = '0;
            period_err_d  = 1'b0;
            timeout_d     = 1'b0;
            done_d        = 1'b0;
          end
        end
        WAIT_EDGE: begin
          if (rise) begin
            start_pulse_d = 1'b1;
            trig_count_d  = new_count;
            per_cnt_d     = 32'd1;
            if (done_hit) done_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 32'd1;
            if (wait_hit) timeout_d = 1'b1;
          end
        end
        RUN: begin
          if (rise) begin
            start_pulse_d = 1'b1;
            trig_count_d  = new_count;
            last_period_d = per_cnt_q;
            per_cnt_d     = 32'd1;
            if (per_bad)  period_err_d = 1'b1;
            if (done_hit) done_d = 1'b1;
          end else begin
            per_cnt_d = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + 32'd1;
            if (per_hit) timeout_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_pulse = start_pulse_q;
  assign bus.trig_count  = trig_count_q;
  assign bus.last_period = last_period_q;
  assign bus.period_err  = period_err_q;
  assign bus.timeout     = timeout_q;
  assign bus.done        = done_q;
  assign bus.state       = state_q;

endmodule
